// File: rtl/sdram_pkg.sv
// Shared SDRAM port definitions: command encodings and the burst-processor FSM states.
package sdram_pkg;

  localparam logic [1:0] CMD_IDLE  = 2'd0;
  localparam logic [1:0] CMD_READ  = 2'd1;
  localparam logic [1:0] CMD_WRITE = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_WAIT_PROC,
    ST_WRITE
  } fb_state_t;

endpackage

// File: rtl/fb_sync_fifo.sv
// First-word-fall-through synchronous FIFO with full/empty/count; DEPTH must be a power of two.
module fb_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Storage carries no reset; validity is tracked entirely by the pointers.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + (AW+1)'(1);
        2'b01:   count_reg <= count_reg - (AW+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == (AW+1)'(DEPTH));
  assign count   = count_reg;
  assign rd_data = empty ? '0 : mem[rd_ptr_reg];

endmodule

// File: rtl/fb_burst_processor.sv
// Framebuffer read-modify-write burst engine: per-lane add of a step, written back in place.
// Define FB_PROC_SATURATE_EN to saturate each lane add instead of wrapping.
module fb_burst_processor
  import sdram_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int LANE_W      = 8,
  parameter int ADDR_W      = 22,
  parameter int BURST_LEN   = 8,
  parameter int FIFO_DEPTH  = 16,
  parameter int FRAME_WORDS = 96000
) (
  input  logic              i_Clk,
  input  logic              i_Rst_n,
  input  logic              i_Enable,
  input  logic [LANE_W-1:0] i_Step,
  input  logic              i_Data_Read_Valid,
  input  logic [DATA_W-1:0] i_Data_Read,
  input  logic              i_Data_Write_Done,
  input  logic              i_SDRAM_Requested,
  output logic              o_SDRAM_Yield,
  output logic [1:0]        o_Command,
  output logic [ADDR_W-1:0] o_Data_Address,
  output logic [DATA_W-1:0] o_Data_Write,
  output logic              o_Frame_Done,
  output logic              o_Busy
);

  localparam int LANES = DATA_W / LANE_W;
  localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int FC_W  = $clog2(FIFO_DEPTH) + 1;

  localparam logic [CNT_W-1:0]  BEAT_LAST  = CNT_W'(BURST_LEN - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE   = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] BURST_STEP = ADDR_W'(BURST_LEN);
  localparam logic [ADDR_W-1:0] FRAME_END  = ADDR_W'(FRAME_WORDS);

  fb_state_t         state_reg;
  fb_state_t         state_next;
  logic [ADDR_W-1:0] addr_reg;
  logic [ADDR_W-1:0] base_reg;
  logic [ADDR_W-1:0] base_next;
  logic [CNT_W-1:0]  beat_reg;
  logic [LANE_W-1:0] step_reg;
  logic              frame_done_reg;
  logic [DATA_W-1:0] proc_data_reg;
  logic              proc_valid_reg;
  logic [DATA_W-1:0] lane_sum;

  logic [DATA_W-1:0] rd_data;
  logic              rd_full;
  logic              rd_empty;
  logic [FC_W-1:0]   rd_count;
  logic              wb_full;
  logic              wb_empty;
  logic [FC_W-1:0]   wb_count;

  logic start;
  logic read_beat;
  logic write_beat;
  logic last_beat;
  logic wb_ready;
  logic proc_pop;

  assign start      = (state_reg == ST_IDLE) && i_Enable && !i_SDRAM_Requested
                      && rd_empty && wb_empty;
  assign read_beat  = (state_reg == ST_READ) && i_Data_Read_Valid && !rd_full;
  assign write_beat = (state_reg == ST_WRITE) && i_Data_Write_Done && !wb_empty;
  assign last_beat  = (beat_reg == '0);
  assign wb_ready   = (wb_count == FC_W'(BURST_LEN));
  assign proc_pop   = !rd_empty && !wb_full;
  assign base_next  = base_reg + BURST_STEP;

  fb_sync_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_readout_fifo (
    .clk     (i_Clk),
    .rst_n   (i_Rst_n),
    .push    (read_beat),
    .wr_data (i_Data_Read),
    .pop     (proc_pop),
    .rd_data (rd_data),
    .full    (rd_full),
    .empty   (rd_empty),
    .count   (rd_count)
  );

  fb_sync_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_writeback_fifo (
    .clk     (i_Clk),
    .rst_n   (i_Rst_n),
    .push    (proc_valid_reg),
    .wr_data (proc_data_reg),
    .pop     (write_beat),
    .rd_data (o_Data_Write),
    .full    (wb_full),
    .empty   (wb_empty),
    .count   (wb_count)
  );

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
`ifdef FB_PROC_SATURATE_EN
      logic [LANE_W:0] sum;
      assign sum = {1'b0, rd_data[gi*LANE_W +: LANE_W]} + {1'b0, step_reg};
      assign lane_sum[gi*LANE_W +: LANE_W] = sum[LANE_W] ? '1 : sum[LANE_W-1:0];
`else
      assign lane_sum[gi*LANE_W +: LANE_W] = rd_data[gi*LANE_W +: LANE_W] + step_reg;
`endif
    end
  endgenerate

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:      if (start) state_next = ST_READ;
      ST_READ:      if (read_beat && last_beat) state_next = ST_WAIT_PROC;
      ST_WAIT_PROC: if (wb_ready) state_next = ST_WRITE;
      ST_WRITE:     if (write_beat && last_beat) state_next = ST_IDLE;
      default:      state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    o_Command = CMD_IDLE;
    case (state_reg)
      ST_READ:  o_Command = CMD_READ;
      ST_WRITE: o_Command = CMD_WRITE;
      default:  o_Command = CMD_IDLE;
    endcase
    o_SDRAM_Yield = i_SDRAM_Requested && (state_reg == ST_IDLE);
    o_Busy        = (state_reg != ST_IDLE) || (rd_count != '0) || (wb_count != '0);
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      addr_reg       <= '0;
      base_reg       <= '0;
      beat_reg       <= '0;
      step_reg       <= '0;
      frame_done_reg <= 1'b0;
    end else begin
      frame_done_reg <= 1'b0;
      if (start) begin
        addr_reg <= base_reg;
        beat_reg <= BEAT_LAST;
        step_reg <= i_Step;
      end else if (read_beat || write_beat) begin
        addr_reg <= addr_reg + ADDR_ONE;
        if (!last_beat) begin
          beat_reg <= beat_reg - CNT_W'(1);
        end
      end else if ((state_reg == ST_WAIT_PROC) && wb_ready) begin
        addr_reg <= base_reg;
        beat_reg <= BEAT_LAST;
      end
      // Frame wrap is judged on the burst base, never on the running address.
      if (write_beat && last_beat) begin
        if (base_next == FRAME_END) begin
          base_reg       <= '0;
          frame_done_reg <= 1'b1;
        end else begin
          base_reg <= base_next;
        end
      end
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      proc_valid_reg <= 1'b0;
      proc_data_reg  <= '0;
    end else begin
      proc_valid_reg <= proc_pop;
      if (proc_pop) begin
        proc_data_reg <= lane_sum;
      end
    end
  end

  assign o_Data_Address = addr_reg;
  assign o_Frame_Done   = frame_done_reg;

endmodule

// File: tb/tb_fb_burst_processor.sv
// Scoreboard bench for fb_burst_processor with an SDRAM responder and a lane-add reference model.
module tb_fb_burst_processor;
  import sdram_pkg::*;

  localparam int FW = 32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_Enable;
  logic [7:0]  i_Step;
  logic        i_Data_Read_Valid;
  logic [31:0] i_Data_Read;
  logic        i_Data_Write_Done;
  logic        i_SDRAM_Requested;
  logic        o_SDRAM_Yield;
  logic [1:0]  o_Command;
  logic [21:0] o_Data_Address;
  logic [31:0] o_Data_Write;
  logic        o_Frame_Done;
  logic        o_Busy;

  fb_burst_processor #(.FRAME_WORDS(FW)) dut (
    .i_Clk             (clk),
    .i_Rst_n           (rst_n),
    .i_Enable          (i_Enable),
    .i_Step            (i_Step),
    .i_Data_Read_Valid (i_Data_Read_Valid),
    .i_Data_Read       (i_Data_Read),
    .i_Data_Write_Done (i_Data_Write_Done),
    .i_SDRAM_Requested (i_SDRAM_Requested),
    .o_SDRAM_Yield     (o_SDRAM_Yield),
    .o_Command         (o_Command),
    .o_Data_Address    (o_Data_Address),
    .o_Data_Write      (o_Data_Write),
    .o_Frame_Done      (o_Frame_Done),
    .o_Busy            (o_Busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [21:0] addr;
    logic [31:0] data;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] sdram   [FW];
  logic [31:0] ref_mem [FW];
  int          checks = 0;
  int          errors = 0;
  int          duty = 100;
  int          wr_limit = 100;
  int          wr_resp_cnt = 0;
  logic [21:0] rd_base = '0;
  int          rd_beat = 0;
  logic [21:0] wr_base = '0;
  int          wr_beat = 0;
  int          bursts_done = 0;
  int          exp_wraps = 0;
  int          frame_cnt = 0;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  // Reference: every byte lane gets step added, clipped or wrapped at 8 bits.
  function automatic logic [31:0] ref_proc(logic [31:0] w, logic [7:0] s);
    logic [31:0] r;
    r = '0;
    for (int l = 0; l < 4; l++) begin
      int v;
      v = int'(w[l*8 +: 8]) + int'(s);
`ifdef FB_PROC_SATURATE_EN
      if (v > 255) v = 255;
`else
      v = v % 256;
`endif
      r[l*8 +: 8] = v[7:0];
    end
    return r;
  endfunction

  // SDRAM responder: serves reads from sdram[], records writes, issues stray strobes when idle.
  initial begin : responder
    exp_t        e;
    logic [21:0] a;
    i_Data_Read_Valid = 1'b0;
    i_Data_Read       = '0;
    i_Data_Write_Done = 1'b0;
    forever begin
      @(negedge clk);
      if (o_Command == CMD_READ && $urandom_range(99) < duty) begin
        a = rd_base + 22'(rd_beat);
        check("rd_addr", 64'(o_Data_Address), 64'(a));
        i_Data_Read_Valid = 1'b1;
        i_Data_Read       = sdram[o_Data_Address[4:0]];
        e.addr = a;
        e.data = ref_proc(ref_mem[a[4:0]], i_Step);
        exp_q.push_back(e);
        rd_beat++;
        if (rd_beat == 8) begin
          rd_beat = 0;
          rd_base = (rd_base + 22'd8) % 22'(FW);
        end
        wr_resp_cnt = 0;
      end else begin
        i_Data_Read_Valid = (o_Command != CMD_READ) && ($urandom_range(1) == 1);
        i_Data_Read       = $urandom;
      end
      if (o_Command == CMD_WRITE && wr_resp_cnt < wr_limit && $urandom_range(99) < duty) begin
        i_Data_Write_Done = 1'b1;
        sdram[o_Data_Address[4:0]] = o_Data_Write;
        wr_resp_cnt++;
      end else begin
        i_Data_Write_Done = (o_Command != CMD_WRITE) && ($urandom_range(1) == 1);
      end
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (o_Frame_Done) frame_cnt++;
      if (rst_n && o_Command == CMD_WRITE && i_Data_Write_Done) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_underflow: write beat addr 0x%0h with no expected entry", o_Data_Address);
        end else begin
          e = exp_q.pop_front();
          $display("wr addr=0x%0h data=0x%08h exp_addr=0x%0h exp_data=0x%08h",
                   o_Data_Address, o_Data_Write, e.addr, e.data);
          check("wr_addr", 64'(o_Data_Address), 64'(e.addr));
          check("wr_data", 64'(o_Data_Write), 64'(e.data));
          ref_mem[e.addr[4:0]] = e.data;
          wr_beat++;
          if (wr_beat == 8) begin
            wr_beat = 0;
            bursts_done++;
            wr_base = wr_base + 22'd8;
            if (wr_base == 22'(FW)) begin
              wr_base = '0;
              exp_wraps++;
            end
          end
        end
      end
    end
  end

  task automatic run_burst();
    int         target;
    int         cyc;
    logic [1:0] seq[$];
    logic [9:0] pk;
    target = bursts_done + 1;
    cyc    = 0;
    pk     = '0;
    seq.push_back(o_Command);
    i_Enable = 1'b1;
    while (!(bursts_done >= target && !o_Busy) && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (o_Command != CMD_IDLE) i_Enable = 1'b0;
      if (o_Command != seq[seq.size()-1]) seq.push_back(o_Command);
    end
    i_Enable = 1'b0;
    check("burst_timeout", 64'(cyc < 3000), 64'd1);
    for (int i = 0; i < seq.size() && i < 5; i++) pk = {pk[7:0], seq[i]};
    check("cmd_seq", {50'(seq.size()), 4'd0, pk}, {50'd5, 4'd0, CMD_IDLE, CMD_READ, CMD_IDLE, CMD_WRITE, CMD_IDLE});
  endtask

  initial begin : main
    int  target;
    int  cyc;
    int  mism;
    logic bad;
    rst_n = 1'b0;
    i_Enable = 1'b0;
    i_Step = 8'd1;
    i_SDRAM_Requested = 1'b0;
    for (int i = 0; i < FW; i++) begin
      sdram[i] = $urandom;
    end
    for (int i = 0; i < 8; i++) sdram[i] = 32'h0001_0203 + 32'(i) * 32'h0404_0404;
    sdram[8] = 32'hF8F0_0102;
    for (int i = 0; i < FW; i++) ref_mem[i] = sdram[i];

    repeat (3) @(negedge clk);
    check("rst_cmd", 64'(o_Command), 64'(CMD_IDLE));
    check("rst_addr", 64'(o_Data_Address), 64'd0);
    check("rst_busy", 64'(o_Busy), 64'd0);
    check("rst_frame_done", 64'(o_Frame_Done), 64'd0);
    check("rst_data_write", 64'(o_Data_Write), 64'd0);
    check("rst_yield", 64'(o_SDRAM_Yield), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed bursts: incrementing pattern, then lane overflow.
    run_burst();
    check("burst0_word0", 64'(sdram[0]), 64'h0102_0304);
    check("burst0_word7", 64'(sdram[7]), 64'h1D1E_1F20);
    i_Step = 8'h10;
    run_burst();
`ifdef FB_PROC_SATURATE_EN
    check("lane_overflow", 64'(sdram[8]), 64'hFFFF_1112);
`else
    check("lane_overflow", 64'(sdram[8]), 64'h0800_1112);
`endif

    // Request held while idle: port yielded, no command issued.
    i_SDRAM_Requested = 1'b1;
    i_Enable = 1'b1;
    bad = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (!o_SDRAM_Yield || o_Command != CMD_IDLE) bad = 1'b1;
    end
    check("idle_yield_hold", 64'(bad), 64'd0);

    // Request raised mid-READ: no yield until the write-back completes.
    i_SDRAM_Requested = 1'b0;
    i_Step = $urandom;
    target = bursts_done + 1;
    cyc = 0;
    while (o_Command != CMD_READ && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("arb_start_timeout", 64'(cyc < 100), 64'd1);
    i_Enable = 1'b0;
    i_SDRAM_Requested = 1'b1;
    bad = 1'b0;
    cyc = 0;
    while (bursts_done < target && cyc < 500) begin
      if (o_SDRAM_Yield) bad = 1'b1;
      @(negedge clk);
      cyc++;
    end
    check("arb_no_early_yield", 64'(bad), 64'd0);
    check("arb_yield_after", 64'(o_SDRAM_Yield), 64'd1);
    check("arb_cmd_after", 64'(o_Command), 64'(CMD_IDLE));
    i_SDRAM_Requested = 1'b0;
    @(negedge clk);

    // Randomized steps with 30% read/write strobe duty; crosses the frame wrap.
    duty = 30;
    for (int b = 0; b < 6; b++) begin
      i_Step = $urandom;
      run_burst();
    end

    // Reset after three write beats of a burst.
    duty = 100;
    wr_limit = 3;
    i_Step = $urandom;
    i_Enable = 1'b1;
    cyc = 0;
    while (!(o_Command == CMD_WRITE && wr_resp_cnt == 3) && cyc < 500) begin
      @(negedge clk);
      cyc++;
      if (o_Command != CMD_IDLE) i_Enable = 1'b0;
    end
    i_Enable = 1'b0;
    check("rst_mid_timeout", 64'(cyc < 500), 64'd1);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_cmd", 64'(o_Command), 64'(CMD_IDLE));
    check("rst_mid_addr", 64'(o_Data_Address), 64'd0);
    check("rst_mid_busy", 64'(o_Busy), 64'd0);
    exp_q.delete();
    rd_base = '0;
    rd_beat = 0;
    wr_base = '0;
    wr_beat = 0;
    wr_limit = 100;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    i_Step = $urandom;
    run_burst();

    mism = 0;
    for (int i = 0; i < FW; i++) if (sdram[i] !== ref_mem[i]) mism++;
    check("mem_final", 64'(mism), 64'd0);
    check("frame_done_count", 64'(frame_cnt), 64'(exp_wraps));
    check("sb_empty", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
